chk_instr_progress_mw: RTL and testbench
========================================

CHK_INSTR_PROGRESS_MW -- requirements
Module: chk_instr_progress_mw

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- A, "A", display name of the source stage.
- B, "B", display name of the destination stage.
- NA, 2, number of stage-A lanes (1..8).
- NB, 2, number of stage-B lanes (1..8).
- STALL_MAX, 64, maximum number of cycles one fid may stay in stage A (2..65535).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- reset, in, 1, asynchronous active-high reset.
- br_mispred_rb1, in, 1, flush indication.
- valid_stgA_nn0, in, NA, per-lane stage-A valid.
- simid_stgA_nn0, in, NA x t_simid, per-lane stage-A simid.
- valid_stgB_nn0, in, NB, per-lane stage-B valid.
- simid_stgB_nn0, in, NB x t_simid, per-lane stage-B simid.
- err_lost, out, 1, registered lost-instruction flag.
- err_grew, out, 1, registered duplicated-instruction flag.
- err_dup, out, 1, registered intra-stage duplicate-fid flag.
- err_stuck, out, 1, registered residency-timeout pulse.
- err_cnt, out, 16, saturating total error count.
- max_resid, out, 16, highest residency observed.
REQ-003 Matching SHALL compare txid.fid only; other simid fields SHALL be ignored.

Function
REQ-004 Stage-A valid and simid per lane SHALL be captured every cycle into nn1 copies.
REQ-005 A fid has left A when it is valid in lane i at nn1 and absent from every valid A lane at nn0.
REQ-006 Lost: some fid has left A, it is absent from every valid B lane at nn0, and br_mispred_rb1=0.
REQ-007 Grew: some fid valid at A nn1 is still present in A nn0 and also present in a valid B lane at nn0.
REQ-008 Dup: two distinct valid A lanes at nn0 carry the same fid.
REQ-009 Each error flag SHALL be the registered OR over all lanes of its condition, asserting exactly one cycle after the nn0 compare cycle.
REQ-010 Per-lane residency counters (16 bit) SHALL be kept for stage A:
- Lane j at nn0 carrying a fid that was valid in any nn1 lane k gets counter(k)+1, saturating at STALL_MAX; lane moves are tracked.
- A new fid loads 1.
- An invalid lane loads 0.
REQ-011 err_stuck SHALL pulse for one cycle when a lane counter first reaches STALL_MAX; it SHALL NOT re-pulse while that counter stays saturated.
REQ-012 When br_mispred_rb1=1, all residency counters SHALL load 0 in that cycle, and lost SHALL be suppressed.
REQ-013 err_cnt SHALL add the number of error flags asserted in a cycle (0..4), saturating at 16'hFFFF.
REQ-014 max_resid SHALL hold the running maximum of all lane counters; it SHALL be non-decreasing except at reset.
REQ-015 Each error condition SHALL also fire a VASSERT whose message contains A, B and format_simid of the offending simid.
REQ-016 Simultaneous conditions SHALL all be flagged in the same cycle; no priority between them.

Reset
REQ-017 While reset=1, the following SHALL be 0: the nn1 valids, all counters, err_lost, err_grew, err_dup, err_stuck, err_cnt and max_resid.
REQ-018 Assertions SHALL be disabled while reset=1 and for the first cycle after reset deasserts, because nn1 holds no valid history then.
REQ-019 A reset asserted mid-stall SHALL discard the residency state; the next err_stuck requires a further STALL_MAX cycles.

Structure
REQ-020 The following SHALL live in the verif package: t_simid and format_simid (existing), plus a new t_chk_err packed struct {lost, grew, dup, stuck}.
REQ-021 A combinational sub-module chk_fid_lookup (parameter N) SHALL return hit and the one-hot hit index of a fid across N valid/simid lanes.
REQ-022 chk_fid_lookup SHALL be instantiated for the A-nn0, A-nn1 and B-nn0 searches.
REQ-023 Flops SHALL use the existing DFF macros, with async-reset variants for the state in REQ-017.

Verification
REQ-024 NA=NB=2. fid 5 in A lane0, next cycle in B lane1, absent from A -> no errors; err_cnt=0.
REQ-025 fid 7 in A lane0, next cycle absent from A and B, mispred=0 -> err_lost=1 one cycle later; err_cnt=1. Same stimulus with mispred=1 -> no error.
REQ-026 fid 9 held in A lane1 while also driven in B lane0 -> err_grew=1 each cycle it persists; err_cnt increments by 1 per cycle.
REQ-027 fid 3 in both A lanes in the same cycle -> err_dup=1 next cycle.
REQ-028 STALL_MAX=4, fid 2 held in A for 6 cycles, moving lane0 to lane1 at cycle 2 -> exactly one err_stuck pulse, in the cycle after the 4th cycle of residency; max_resid=4.
REQ-029 Drive err_cnt toward 16'hFFFF with 3 simultaneous errors per cycle -> err_cnt saturates at 16'hFFFF. Assert reset mid-operation -> all outputs are 0 within the reset cycle.

Source files
------------

// File: rtl/chk_instr_progress_mw_pkg.sv
// rtl/chk_instr_progress_mw_pkg.sv - shared types, flop macros and helpers for the progress checker
//
// Purpose: simulation-id types, simid formatting, error-flag struct, flop and
// assertion macros used by chk_instr_progress_mw and chk_fid_lookup.
// Ports: none (package).

`ifndef CHK_INSTR_PROGRESS_MW_MACROS
`define CHK_INSTR_PROGRESS_MW_MACROS
// Plain flop, no reset.
`define DFF(q_, d_, clk_) \
  always_ff @(posedge clk_) q_ <= d_;
// Flop with asynchronous active-high reset to rstv_.
`define DFFAR(q_, d_, rstv_, clk_, rst_) \
  always_ff @(posedge clk_ or posedge rst_) if (rst_) q_ <= rstv_; else q_ <= d_;
// Checker assertion: cond must hold, otherwise report msg.
`define VASSERT(cond_, msg_) \
  assert (cond_) else $error("%s", msg_)
`endif

package chk_instr_progress_mw_pkg;

  typedef logic [7:0] t_fid;

  typedef struct packed {
    t_fid       fid;
    logic [7:0] seq;
  } t_txid;

  typedef struct packed {
    logic [3:0] thread;
    t_txid      txid;
  } t_simid;

  typedef struct packed {
    logic lost;
    logic grew;
    logic dup;
    logic stuck;
  } t_chk_err;

  function automatic string format_simid(t_simid s);
    return $sformatf("t%0d.f%0d.s%0d", s.thread, s.txid.fid, s.txid.seq);
  endfunction

endpackage

// File: rtl/chk_fid_lookup.sv
// rtl/chk_fid_lookup.sv - combinational fid search across N valid/simid lanes
//
// Purpose: report whether fid is carried by any valid lane, plus a one-hot
// index of the lowest matching lane.
// Ports:
//   fid    - fid to search for
//   valid  - per-lane valid
//   simid  - per-lane simid (only txid.fid is compared)
//   hit    - some valid lane carries fid
//   hitIdx - one-hot lowest matching lane, zero when no hit

module chk_fid_lookup
  import chk_instr_progress_mw_pkg::*;
#(
  parameter int N = 2
) (
  input  t_fid             fid,
  input  logic [N-1:0]     valid,
  input  t_simid [N-1:0]   simid,
  output logic             hit,
  output logic [N-1:0]     hitIdx
);

  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    for (int i = 0; i < N; i++) begin
      if (!hit && valid[i] && simid[i].txid.fid == fid) begin
        hit       = 1'b1;
        hitIdx[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chk_instr_progress_mw.sv
// rtl/chk_instr_progress_mw.sv - instruction progress checker between pipeline stages A and B
//
// Purpose: watches fids leaving stage A and flags lost, duplicated (grew),
// intra-stage duplicate and stage-A residency-timeout conditions.
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   br_mispred_rb1         - flush: clears residency, suppresses lost
//   valid/simid_stgA_nn0   - stage-A lanes this cycle
//   valid/simid_stgB_nn0   - stage-B lanes this cycle
//   err_lost/grew/dup      - registered error flags
//   err_stuck              - one-cycle pulse when a lane first hits STALL_MAX
//   err_cnt                - saturating total of asserted flags
//   max_resid              - running maximum residency

module chk_instr_progress_mw
  import chk_instr_progress_mw_pkg::*;
#(
  parameter string A          = "A",
  parameter string B          = "B",
  parameter int    NA         = 2,
  parameter int    NB         = 2,
  parameter int    STALL_MAX  = 64,
  parameter bit    VASSERT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_mispred_rb1,
  input  logic [NA-1:0]     valid_stgA_nn0,
  input  t_simid [NA-1:0]   simid_stgA_nn0,
  input  logic [NB-1:0]     valid_stgB_nn0,
  input  t_simid [NB-1:0]   simid_stgB_nn0,
  output logic              err_lost,
  output logic              err_grew,
  output logic              err_dup,
  output logic              err_stuck,
  output logic [15:0]       err_cnt,
  output logic [15:0]       max_resid
);

  localparam logic [15:0] SM16 = 16'(STALL_MAX);

  logic [NA-1:0]           validA1;
  t_simid [NA-1:0]         simidA1;
  logic [NA-1:0]           inA0, inB0, hitA1;
  logic [NA-1:0][NA-1:0]   srcIdx;
  logic [NA-1:0][NA-1:0]   unusedIdxA0;
  logic [NA-1:0][NB-1:0]   unusedIdxB0;
  logic [NA-1:0]           lostLane, grewLane, dupLane, stuckLane;
  logic [NA-1:0][15:0]     cnt, cntNxt, srcCnt;
  logic [15:0]             maxResid, maxNxt, errCnt, errCntNxt;
  logic [16:0]             cntSum;
  logic [2:0]              nErr;
  t_chk_err                errNext, errQ;
  logic                    assertArm;

  `DFFAR(validA1, valid_stgA_nn0, '0, clk, reset)
  `DFF(simidA1, simid_stgA_nn0, clk)

  // Per nn1 lane: is its fid still in A, or already in B? Per nn0 lane: where
  // was its fid last cycle (one-hot), so residency follows lane moves.
  for (genvar i = 0; i < NA; i++) begin : g_lookup
    chk_fid_lookup #(.N(NA)) uA0 (
      .fid(simidA1[i].txid.fid), .valid(valid_stgA_nn0), .simid(simid_stgA_nn0),
      .hit(inA0[i]), .hitIdx(unusedIdxA0[i]));
    chk_fid_lookup #(.N(NB)) uB0 (
      .fid(simidA1[i].txid.fid), .valid(valid_stgB_nn0), .simid(simid_stgB_nn0),
      .hit(inB0[i]), .hitIdx(unusedIdxB0[i]));
    chk_fid_lookup #(.N(NA)) uA1 (
      .fid(simid_stgA_nn0[i].txid.fid), .valid(validA1), .simid(simidA1),
      .hit(hitA1[i]), .hitIdx(srcIdx[i]));
  end

  always_comb begin
    lostLane  = validA1 & ~inA0 & ~inB0 & {NA{~br_mispred_rb1}};
    grewLane  = validA1 & inA0 & inB0;
    dupLane   = '0;
    cntNxt    = '0;
    srcCnt    = '0;
    stuckLane = '0;
    maxNxt    = maxResid;
    for (int j = 0; j < NA; j++) begin
      for (int k = j + 1; k < NA; k++) begin
        if (valid_stgA_nn0[j] && valid_stgA_nn0[k] &&
            simid_stgA_nn0[j].txid.fid == simid_stgA_nn0[k].txid.fid)
          dupLane[j] = 1'b1;
      end
      for (int k = 0; k < NA; k++) begin
        if (srcIdx[j][k]) srcCnt[j] = srcCnt[j] | cnt[k];
      end
      if (!br_mispred_rb1 && valid_stgA_nn0[j]) begin
        if (hitA1[j])
          cntNxt[j] = (srcCnt[j] >= SM16) ? SM16 : srcCnt[j] + 16'd1;
        else
          cntNxt[j] = 16'd1;
        // Only the transition into saturation pulses; a source already at
        // STALL_MAX means this fid has been reported.
        stuckLane[j] = (cntNxt[j] == SM16) && !(hitA1[j] && srcCnt[j] == SM16);
      end
      if (cntNxt[j] > maxNxt) maxNxt = cntNxt[j];
    end
    errNext   = '{lost: |lostLane, grew: |grewLane, dup: |dupLane, stuck: |stuckLane};
    nErr      = 3'(errNext.lost) + 3'(errNext.grew) + 3'(errNext.dup) + 3'(errNext.stuck);
    cntSum    = {1'b0, errCnt} + 17'(nErr);
    errCntNxt = cntSum[16] ? 16'hFFFF : cntSum[15:0];
  end

  `DFFAR(cnt, cntNxt, '0, clk, reset)
  `DFFAR(maxResid, maxNxt, '0, clk, reset)
  `DFFAR(errQ, errNext, '0, clk, reset)
  `DFFAR(errCnt, errCntNxt, '0, clk, reset)
  // Low through reset and the first cycle after it: nn1 has no history yet.
  `DFFAR(assertArm, 1'b1, 1'b0, clk, reset)

  assign err_lost  = errQ.lost;
  assign err_grew  = errQ.grew;
  assign err_dup   = errQ.dup;
  assign err_stuck = errQ.stuck;
  assign err_cnt   = errCnt;
  assign max_resid = maxResid;

  always @(posedge clk) begin
    if (VASSERT_EN && assertArm) begin
      for (int i = 0; i < NA; i++) begin
        `VASSERT(!lostLane[i], $sformatf("%s->%s lost %s", A, B, format_simid(simidA1[i])));
        `VASSERT(!grewLane[i], $sformatf("%s->%s grew %s", A, B, format_simid(simidA1[i])));
        `VASSERT(!dupLane[i], $sformatf("%s->%s dup %s", A, B, format_simid(simid_stgA_nn0[i])));
        `VASSERT(!stuckLane[i], $sformatf("%s->%s stuck %s", A, B, format_simid(simid_stgA_nn0[i])));
      end
    end
  end

endmodule

// File: tb/tb_chk_instr_progress_mw.sv
// tb/tb_chk_instr_progress_mw.sv - scoreboard bench for chk_instr_progress_mw

module tb_chk_instr_progress_mw;
  import chk_instr_progress_mw_pkg::*;

  localparam int SM = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            mp = 1'b0;
  logic [1:0]      vA = '0, vB = '0;
  t_simid [1:0]    sA = '0, sB = '0;
  logic            err_lost, err_grew, err_dup, err_stuck;
  logic [15:0]     err_cnt, max_resid;

  chk_instr_progress_mw #(
    .A("SRC"), .B("DST"), .NA(2), .NB(2), .STALL_MAX(SM), .VASSERT_EN(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .br_mispred_rb1(mp),
    .valid_stgA_nn0(vA), .simid_stgA_nn0(sA),
    .valid_stgB_nn0(vB), .simid_stgB_nn0(sB),
    .err_lost(err_lost), .err_grew(err_grew), .err_dup(err_dup), .err_stuck(err_stuck),
    .err_cnt(err_cnt), .max_resid(max_resid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    bit lost, grew, dup, stuck;
    int cnt, maxr;
  } exp_t;

  exp_t sbq[$];
  exp_t mon;
  int   cyc = 0;
  int   vectors = 0, miscompares = 0;
  bit   inReset = 1'b0;

  // Reference model: fid-keyed residency, sets of fids per stage.
  int   prevF[$];
  int   resid[int];
  int   mCnt = 0, mMax = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit has(input int q[$], input int f);
    foreach (q[i]) if (q[i] == f) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic checkEntry(input exp_t e);
    vectors++;
    if ({err_lost, err_grew, err_dup, err_stuck} !== {e.lost, e.grew, e.dup, e.stuck} ||
        err_cnt !== 16'(e.cnt) || max_resid !== 16'(e.maxr)) begin
      miscompares++;
      $display("FAIL scoreboard cyc=%0d: got lgds=%b%b%b%b cnt=%0d max=%0d, expected lgds=%b%b%b%b cnt=%0d max=%0d",
               cyc, err_lost, err_grew, err_dup, err_stuck, err_cnt, max_resid,
               e.lost, e.grew, e.dup, e.stuck, e.cnt, e.maxr);
    end
  endtask

  // Monitor: compares whatever expectation is due this cycle.
  always @(negedge clk) begin
    if (!inReset) begin
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        mon = sbq.pop_front();
        checkEntry(mon);
      end
    end
  end

  task automatic step(input logic [1:0] va, input int fa0, input int fa1,
                      input logic [1:0] vb, input int fb0, input int fb1, input bit m);
    int   curA[$];
    int   curB[$];
    int   fa[2];
    int   fb[2];
    int   nr[int];
    int   old, v;
    exp_t e;
    fa[0] = fa0; fa[1] = fa1; fb[0] = fb0; fb[1] = fb1;
    for (int i = 0; i < 2; i++) begin
      sA[i].thread   = 4'($urandom);
      sA[i].txid.seq = 8'($urandom);
      sA[i].txid.fid = va[i] ? 8'(fa[i]) : 8'($urandom);
      sB[i].thread   = 4'($urandom);
      sB[i].txid.seq = 8'($urandom);
      sB[i].txid.fid = vb[i] ? 8'(fb[i]) : 8'($urandom);
      if (va[i]) curA.push_back(fa[i]);
      if (vb[i]) curB.push_back(fb[i]);
    end
    vA = va; vB = vb; mp = m;
    e = '{due: cyc + 1, lost: 0, grew: 0, dup: 0, stuck: 0, cnt: 0, maxr: 0};
    foreach (prevF[i]) begin
      if (!m && !has(curA, prevF[i]) && !has(curB, prevF[i])) e.lost = 1'b1;
      if (has(curA, prevF[i]) && has(curB, prevF[i])) e.grew = 1'b1;
    end
    for (int i = 0; i < curA.size(); i++)
      for (int j = i + 1; j < curA.size(); j++)
        if (curA[i] == curA[j]) e.dup = 1'b1;
    if (!m) begin
      foreach (curA[i]) begin
        if (has(prevF, curA[i])) begin
          old = resid.exists(curA[i]) ? resid[curA[i]] : 0;
          v = (old + 1 > SM) ? SM : old + 1;
          if (v == SM && old != SM) e.stuck = 1'b1;
        end else begin
          v = 1;
        end
        nr[curA[i]] = v;
        if (v > mMax) mMax = v;
      end
    end
    mCnt = mCnt + int'(e.lost) + int'(e.grew) + int'(e.dup) + int'(e.stuck);
    if (mCnt > 65535) mCnt = 65535;
    e.cnt = mCnt;
    e.maxr = mMax;
    resid = nr;
    prevF = curA;
    sbq.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(2'b00, 0, 0, 2'b00, 0, 0, 1'b0);
  endtask

  task automatic doReset(input int cycles);
    inReset = 1'b1;
    sbq.delete();
    vA = '0; vB = '0; mp = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_lost", int'(err_lost), 0);
    chk("rst_grew", int'(err_grew), 0);
    chk("rst_dup", int'(err_dup), 0);
    chk("rst_stuck", int'(err_stuck), 0);
    chk("rst_cnt", int'(err_cnt), 0);
    chk("rst_max", int'(max_resid), 0);
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    prevF.delete();
    resid.delete();
    mCnt = 0;
    mMax = 0;
    inReset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    #2;
    doReset(3);

    // fid 5 moves A lane0 -> B lane1
    step(2'b01, 5, 0, 2'b00, 0, 0, 1'b0);
    step(2'b00, 0, 0, 2'b10, 0, 5, 1'b0);
    idle();
    chk("req24_cnt", int'(err_cnt), 0);

    // fid 7 vanishes: lost, then the same under mispredict
    step(2'b01, 7, 0, 2'b00, 0, 0, 1'b0);
    idle();
    chk("req25_lost", int'(err_lost), 1);
    chk("req25_cnt", int'(err_cnt), 1);
    step(2'b01, 7, 0, 2'b00, 0, 0, 1'b0);
    step(2'b00, 0, 0, 2'b00, 0, 0, 1'b1);
    chk("req25_mp_lost", int'(err_lost), 0);

    // fid 9 held in A lane1 while in B lane0
    step(2'b10, 0, 9, 2'b01, 9, 0, 1'b0);
    step(2'b10, 0, 9, 2'b01, 9, 0, 1'b0);
    chk("req26_grew", int'(err_grew), 1);
    step(2'b10, 0, 9, 2'b01, 9, 0, 1'b0);
    chk("req26_cnt", int'(err_cnt), 3);
    step(2'b00, 0, 0, 2'b01, 9, 0, 1'b0);

    // fid 3 in both A lanes
    step(2'b11, 3, 3, 2'b00, 0, 0, 1'b0);
    chk("req27_dup", int'(err_dup), 1);
    step(2'b00, 0, 0, 2'b01, 3, 0, 1'b0);

    // fid 2 held 6 cycles, lane0 -> lane1
    pulses = 0;
    for (int s = 0; s < 6; s++) begin
      step((s < 2) ? 2'b01 : 2'b10, 2, 2, 2'b00, 0, 0, 1'b0);
      pulses += int'(err_stuck);
      if (s == 3) chk("req28_stuck_c4", int'(err_stuck), 1);
    end
    chk("req28_pulses", pulses, 1);
    step(2'b00, 0, 0, 2'b01, 2, 0, 1'b0);
    chk("req28_max", int'(max_resid), 4);
    chk("req28_cnt", int'(err_cnt), 5);

    // saturate err_cnt: alternating {1,6} / {1,1} with 1 in B
    for (int n = 0; n < 30000 && mCnt < 65535; n++) begin
      step(2'b11, 1, 6, 2'b01, 1, 0, 1'b0);
      step(2'b11, 1, 1, 2'b01, 1, 0, 1'b0);
    end
    step(2'b11, 1, 6, 2'b01, 1, 0, 1'b0);
    step(2'b11, 1, 1, 2'b01, 1, 0, 1'b0);
    chk("req29_sat", int'(err_cnt), 65535);
    doReset(2);

    // randomized traffic over a small fid space
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 699) == 0) doReset(1);
      step(2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
           2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 15) == 0);
    end
    idle();
    idle();
    @(negedge clk); #1;
    chk("sb_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
